// File: rtl/fdivsqrt_resid_resolve.sv
// fdivsqrt_resid_resolve
// Takes the final redundant residual (WS, WC) and the on-the-fly quotient pair (U, UM) from the
// divsqrt iteration loop. The residual sign and zero flag are resolved with a carry-propagate add
// that covers CW bits per cycle, LSB slice first. The block then returns the corrected quotient:
// UM if the residual is negative, U otherwise. It also returns Neg and Sticky (residual nonzero).
module fdivsqrt_resid_resolve #(
  parameter int RW = 32,
  parameter int QW = 29,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [RW-1:0] WS,
  input  logic [RW-1:0] WC,
  input  logic [QW-1:0] U,
  input  logic [QW-1:0] UM,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [QW-1:0] Quot,
  output logic          Neg,
  output logic          Sticky
);

  localparam int NS = RW / CW;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] ws_reg, wc_reg;
  logic [QW-1:0] u_reg, um_reg;
  logic          carry_reg;
  logic          nz_reg;
  logic [IW-1:0] idx_reg;
  logic [QW-1:0] quot_reg;
  logic          neg_reg;
  logic          sticky_reg;

  logic          accept;
  logic          add_step;
  logic          last_step;

  // Break the latched residual vectors into CW-bit slices so one slice can be selected per cycle.
  logic [CW-1:0] ws_slice [NS];
  logic [CW-1:0] wc_slice [NS];

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slice
      assign ws_slice[gi] = ws_reg[gi*CW +: CW];
      assign wc_slice[gi] = wc_reg[gi*CW +: CW];
    end
  endgenerate

  logic [CW:0] slice_sum;
  assign slice_sum = {1'b0, ws_slice[idx_reg]} + {1'b0, wc_slice[idx_reg]} + {{CW{1'b0}}, carry_reg};

  // The FSM state register. Reset returns the block to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and handshake outputs. Flush overrides every state and blocks any accept.
  always_comb begin
    state_next = state_reg;
    InReady    = 1'b0;
    OutValid   = 1'b0;
    accept     = 1'b0;
    add_step   = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        add_step = 1'b1;
        if (idx_reg == LAST_IDX) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (Flush) begin
      state_next = IDLE;
      accept     = 1'b0;
      add_step   = 1'b0;
      last_step  = 1'b0;
    end
  end

  // Operand latching, the sliced add, and the result registers.
  // The result outputs change only when the final slice finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_reg     <= '0;
      wc_reg     <= '0;
      u_reg      <= '0;
      um_reg     <= '0;
      carry_reg  <= 1'b0;
      nz_reg     <= 1'b0;
      idx_reg    <= '0;
      quot_reg   <= '0;
      neg_reg    <= 1'b0;
      sticky_reg <= 1'b0;
    end else if (Flush) begin
      carry_reg <= 1'b0;
      nz_reg    <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      ws_reg    <= WS;
      wc_reg    <= WC;
      u_reg     <= U;
      um_reg    <= UM;
      carry_reg <= 1'b0;
      nz_reg    <= 1'b0;
      idx_reg   <= '0;
    end else if (add_step) begin
      carry_reg <= slice_sum[CW];
      nz_reg    <= nz_reg | (|slice_sum[CW-1:0]);
      idx_reg   <= idx_reg + IW'(1);
      if (last_step) begin
        // The carry out of the top slice is dropped, so the residual is taken mod 2^RW.
        idx_reg    <= '0;
        neg_reg    <= slice_sum[CW-1];
        sticky_reg <= nz_reg | (|slice_sum[CW-1:0]);
        quot_reg   <= slice_sum[CW-1] ? um_reg : u_reg;
      end
    end
  end

  assign Quot   = quot_reg;
  assign Neg    = neg_reg;
  assign Sticky = sticky_reg;

endmodule

// File: tb/tb_fdivsqrt_resid_resolve.sv
// tb_fdivsqrt_resid_resolve
// Self-checking bench. The model works per transaction: it remembers when a bundle was accepted.
// It reports the result as valid from NS edges after the accept until the output handshake.
// The result itself is computed as (WS+WC) mod 2^RW.
module tb_fdivsqrt_resid_resolve;

  localparam int RW = 32;
  localparam int QW = 29;
  localparam int CW = 8;
  localparam int NS = RW / CW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Flush = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [RW-1:0] WS = '0;
  logic [RW-1:0] WC = '0;
  logic [QW-1:0] U = '0;
  logic [QW-1:0] UM = '0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [QW-1:0] Quot;
  logic          Neg;
  logic          Sticky;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fdivsqrt_resid_resolve #(.RW(RW), .QW(QW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .WS(WS), .WC(WC), .U(U), .UM(UM), .OutValid(OutValid), .OutReady(OutReady),
    .Quot(Quot), .Neg(Neg), .Sticky(Sticky)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [QW-1:0] q;
    logic          n;
    logic          s;
  } res_t;

  function automatic res_t model_eval(input logic [RW-1:0] ws, input logic [RW-1:0] wc,
                                      input logic [QW-1:0] u, input logic [QW-1:0] um);
    logic [RW-1:0] sum;
    res_t r;
    sum = ws + wc;
    r.n = sum[RW-1];
    r.s = (sum != '0);
    r.q = r.n ? um : u;
    return r;
  endfunction

  // Transaction-level model. m_edge counts the rising edges seen so far.
  // m_acc is the number of the edge that accepted the current bundle.
  bit     m_on = 1'b0;
  bit     m_busy = 1'b0;
  longint m_edge = 0;
  longint m_acc = 0;
  res_t   m_res = '0;
  res_t   m_held = '0;
  int     m_txn = 0;

  always @(posedge clk) begin
    m_edge <= m_edge + 1;
    if (reset) begin
      m_busy <= 1'b0;
      m_held <= '0;
      m_on   <= 1'b1;
    end else if (Flush) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (InValid) begin
        m_busy <= 1'b1;
        m_acc  <= m_edge + 1;
        m_res  <= model_eval(WS, WC, U, UM);
      end
    end else if (m_edge + 1 == m_acc + NS) begin
      m_held <= m_res;
    end else if (m_edge >= m_acc + NS && OutReady) begin
      m_busy <= 1'b0;
      m_txn  <= m_txn + 1;
      $display("[TB] txn %0d: Quot=0x%0h Neg=%0b Sticky=%0b", m_txn, m_held.q, m_held.n, m_held.s);
    end
  end

  // Compare the DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (m_on) begin
      chk("InReady", InReady, !m_busy);
      chk("OutValid", OutValid, m_busy && (m_edge >= m_acc + NS));
      chk("Quot", Quot, m_held.q);
      chk("Neg", Neg, m_held.n);
      chk("Sticky", Sticky, m_held.s);
    end
  end

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!InReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) chk({nm, " ready timeout"}, 0, 1);
  endtask

  // Runs one bundle through the DUT and checks it against hand-computed literals.
  // hold is the number of extra DONE cycles with OutReady low.
  task automatic run_op(input string nm, input logic [RW-1:0] ws, input logic [RW-1:0] wc,
                        input logic [QW-1:0] u, input logic [QW-1:0] um,
                        input logic [QW-1:0] eq, input logic en, input logic es,
                        input int hold, input bit keep_valid);
    int n;
    wait_ready(nm);
    WS = ws; WC = wc; U = u; UM = um;
    InValid  = 1'b1;
    OutReady = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!keep_valid) InValid = 1'b0;
    end while (!OutValid && n < 50);
    chk({nm, " latency"}, n - 1, NS);
    chk({nm, " Quot"}, Quot, eq);
    chk({nm, " Neg"}, Neg, en);
    chk({nm, " Sticky"}, Sticky, es);
    for (int i = 0; i < hold; i++) begin
      chk({nm, " InReady held"}, InReady, 0);
      @(negedge clk);
      chk({nm, " OutValid held"}, OutValid, 1);
      chk({nm, " Quot held"}, Quot, eq);
      chk({nm, " Sticky held"}, Sticky, es);
    end
    OutReady = 1'b1;
    @(negedge clk);
    chk({nm, " OutValid after"}, OutValid, 0);
    chk({nm, " InReady after"}, InReady, 1);
    InValid = 1'b0;
  endtask

  initial begin
    res_t r;
    int   n;

    // Hand-computed values that pin the model itself.
    r = model_eval(32'hFFFF_FFF0, 32'h0000_0005, 29'h0AAA_AAAA, 29'h0AAA_AAA9);
    chk("model neg", r.n, 1);
    chk("model quot", r.q, 29'h0AAA_AAA9);
    r = model_eval(32'hFFFF_FFFF, 32'h0000_0001, 29'h0000_0123, 29'h0000_0122);
    chk("model zero", r.s, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset InReady", InReady, 1);
    chk("reset OutValid", OutValid, 0);
    chk("reset Quot", Quot, 0);
    chk("reset Sticky", Sticky, 0);

    // Case 1: small positive residual.
    run_op("c1", 32'h0000_0005, 32'h0000_0003, 29'h0AAA_AAAA, 29'h0AAA_AAA9,
           29'h0AAA_AAAA, 1'b0, 1'b1, 0, 1'b0);
    // Case 2: the carry ripples through every slice and the sum is zero.
    run_op("c2", 32'hFFFF_FFFF, 32'h0000_0001, 29'h0123_4567, 29'h0123_4566,
           29'h0123_4567, 1'b0, 1'b0, 0, 1'b0);
    // Case 3: negative residual, so UM is selected.
    run_op("c3", 32'hFFFF_FFF0, 32'h0000_0005, 29'h0AAA_AAAA, 29'h0AAA_AAA9,
           29'h0AAA_AAA9, 1'b1, 1'b1, 0, 1'b0);
    // Case 4: output back-pressure with InValid held high throughout.
    run_op("c4", 32'h0000_0005, 32'h0000_0003, 29'h0AAA_AAAA, 29'h0AAA_AAA9,
           29'h0AAA_AAAA, 1'b0, 1'b1, 3, 1'b1);

    // Case 5: flush on the second ADD cycle, then a clean case-3 op.
    wait_ready("c5");
    WS = 32'hFFFF_FFFF; WC = 32'h0000_0001; U = 29'h1; UM = 29'h0;
    InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    chk("c5 InReady after flush", InReady, 1);
    chk("c5 OutValid after flush", OutValid, 0);
    repeat (6) begin
      @(negedge clk);
      chk("c5 no OutValid", OutValid, 0);
    end
    run_op("c5b", 32'hFFFF_FFF0, 32'h0000_0005, 29'h0AAA_AAAA, 29'h0AAA_AAA9,
           29'h0AAA_AAA9, 1'b1, 1'b1, 0, 1'b0);

    // Case 6: reset while the result is waiting in DONE.
    wait_ready("c6");
    WS = 32'h0000_0005; WC = 32'h0000_0003; U = 29'h0AAA_AAAA; UM = 29'h0AAA_AAA9;
    InValid  = 1'b1;
    OutReady = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      InValid = 1'b0;
    end while (!OutValid && n < 50);
    chk("c6 reached DONE", OutValid, 1);
    chk("c6 Quot before reset", Quot, 29'h0AAA_AAAA);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    OutReady = 1'b1;
    chk("c6 OutValid", OutValid, 0);
    chk("c6 Quot", Quot, 0);
    chk("c6 Neg", Neg, 0);
    chk("c6 Sticky", Sticky, 0);
    chk("c6 InReady", InReady, 1);

    // Randomized traffic, checked cycle by cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      InValid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: begin
          WS = $urandom;
          WC = -WS + RW'($urandom_range(0, 1));
        end
        1: begin
          WS = $urandom;
          WC = RW'($urandom_range(0, 15));
        end
        2: begin
          WS = {RW{1'b1}} << $urandom_range(0, RW - 1);
          WC = RW'($urandom_range(0, 255));
        end
        default: begin
          WS = $urandom;
          WC = $urandom;
        end
      endcase
      U        = QW'($urandom);
      UM       = U - QW'(1);
      OutReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    InValid  = 1'b0;
    Flush    = 1'b0;
    reset    = 1'b0;
    OutReady = 1'b1;
    repeat (NS + 4) @(negedge clk);
    chk("final idle InReady", InReady, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
